instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_in  in  23  instruction word from instruction source
- instr_valid  in  1  instr_in valid
- instr_ready  out  1  sequencer can accept an instruction
- instr  out  23  registered instruction (IR), held for the whole execution
- state  out  5  execution-state code for the datapath output decoder
- alu_sub  out  1  ALU subtract select
- done  out  1  one-cycle pulse on the final execution cycle
- illegal  out  1  one-cycle pulse on an illegal opcode
- instr_count  out  8  count of completed instructions
- step  in  1  single-step advance; present only when SEQ_SINGLE_STEP_EN is defined

Function
REQ-002 Field map SHALL be: opcode = IR[22:20], Rx = IR[19:16], Ry = IR[15:12].
REQ-003 Opcodes SHALL be: 000 LOAD, 001 MOV, 010 ADD, 011 SUB; 100-111 illegal.
REQ-004 State codes SHALL be: IDLE 00000, LOAD 00001, MOV 00010, ARITH_A 00011, ARITH_G 00100, ARITH_WB 00101.
REQ-005 instr_ready SHALL be 1 exactly when state = IDLE.
REQ-006 Acceptance SHALL occur on a rising edge with instr_valid && instr_ready: IR <= instr_in, and state moves to the opcode's first state on that same edge.
REQ-007 LOAD and MOV SHALL each take one execution cycle, then return to IDLE.
REQ-008 ADD and SUB SHALL sequence ARITH_A -> ARITH_G -> ARITH_WB -> IDLE, one cycle each.
REQ-009 alu_sub SHALL be 1 only in ARITH_G with opcode 011; otherwise 0.
REQ-010 done SHALL be 1 during the final execution state (LOAD, MOV, ARITH_WB) for exactly one cycle per instruction.
REQ-011 instr_count SHALL increment by 1 on each done cycle and wrap 255 -> 0.
REQ-012 An illegal opcode SHALL:
- load IR;
- stay in IDLE;
- pulse illegal for one cycle;
- assert no done and no count increment.
REQ-013 instr_valid SHALL be ignored in any non-IDLE state, and IR SHALL be stable throughout execution.
REQ-014 Back-to-back instructions SHALL be allowed: the first IDLE cycle after done may accept the next instruction.
REQ-015 Outputs SHALL be registered, except that instr_ready, done and alu_sub are decoded from registered state.

Reset
REQ-016 While rst_n = 0, the block SHALL asynchronously force:
- state = IDLE
- IR = 0
- instr_count = 0
- illegal = 0
- done = 0
- alu_sub = 0
- instr_ready = 1
REQ-017 Reset asserted mid-instruction SHALL abandon that instruction, with no done pulse and no count increment.
REQ-018 After rst_n deasserts, the first rising edge SHALL be able to accept an instruction.

Configuration
REQ-019 With SEQ_SINGLE_STEP_EN defined:
- the step port SHALL exist;
- each execution state SHALL hold until a cycle with step = 1, then advance;
- done SHALL pulse only on the advancing cycle of the final state;
- IDLE acceptance SHALL NOT require step.
REQ-020 With SEQ_SINGLE_STEP_EN undefined, the step port SHALL be absent and states SHALL advance every cycle.

Structure
REQ-021 Package seq_pkg SHALL hold:
- state-code constants;
- opcode constants;
- the field bit positions;
- the state enum typedef.
REQ-022 Opcode-to-first-state decode and the legality check SHALL be a combinational sub-module named seq_decode.
REQ-023 The FSM, IR and counter SHALL live in instr_sequencer.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Accept MOV 0x0150000 -> state 00010 for 1 cycle, done = 1, then IDLE; instr_count = 1.
- Accept SUB 0x0320000 -> states 00011, 00100 (alu_sub = 1), 00101 (done = 1), then IDLE.
- Present opcode 111 -> illegal pulses once, state stays 00000, instr_count unchanged.
- Hold instr_valid = 1 with ADD during ARITH_A/G/WB -> no acceptance until IDLE; IR unchanged; next instruction accepted on the first IDLE edge.
- Drop rst_n in ARITH_G -> immediately IDLE with IR = 0; no done; instr_count stays 0.
- With SEQ_SINGLE_STEP_EN defined, ADD with step = 0 for 5 cycles -> holds 00011; three step pulses -> done once; 256 completions wrap instr_count to 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared encodings for the instruction sequencer: instruction field positions,
// opcodes, and the execution-state codes the datapath output decoder keys on.
package seq_pkg;

  localparam int IR_W   = 23;
  localparam int OPC_HI = 22;
  localparam int OPC_LO = 20;
  localparam int RX_HI  = 19;
  localparam int RX_LO  = 16;
  localparam int RY_HI  = 15;
  localparam int RY_LO  = 12;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;

  localparam logic [4:0] ST_IDLE     = 5'b00000;
  localparam logic [4:0] ST_LOAD     = 5'b00001;
  localparam logic [4:0] ST_MOV      = 5'b00010;
  localparam logic [4:0] ST_ARITH_A  = 5'b00011;
  localparam logic [4:0] ST_ARITH_G  = 5'b00100;
  localparam logic [4:0] ST_ARITH_WB = 5'b00101;

  typedef enum logic [4:0] {
    S_IDLE     = ST_IDLE,
    S_LOAD     = ST_LOAD,
    S_MOV      = ST_MOV,
    S_ARITH_A  = ST_ARITH_A,
    S_ARITH_G  = ST_ARITH_G,
    S_ARITH_WB = ST_ARITH_WB
  } state_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decode: first execution state and legality.
// Illegal opcodes map to IDLE so the FSM simply stays put.
module seq_decode
  import seq_pkg::*;
(
  input  logic [2:0] opcode,
  output state_t     first_state,
  output logic       legal
);

  always_comb begin
    first_state = S_IDLE;
    legal       = 1'b1;
    case (opcode)
      OP_LOAD:        first_state = S_LOAD;
      OP_MOV:         first_state = S_MOV;
      OP_ADD, OP_SUB: first_state = S_ARITH_A;
      default:        legal       = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: IR, execution FSM and completed-instruction counter.
// Define SEQ_SINGLE_STEP_EN to add the step port and hold each execution state until stepped.
module instr_sequencer
  import seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IR_W-1:0] instr_in,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [IR_W-1:0] instr,
  output logic [4:0]      state,
  output logic            alu_sub,
  output logic            done,
  output logic            illegal,
  output logic [7:0]      instr_count
`ifdef SEQ_SINGLE_STEP_EN
  ,
  input  logic            step
`endif
);

  state_t st;
  state_t first_state;
  logic   legal;
  logic   adv;
  logic   accept;

  seq_decode u_dec (
    .opcode      (instr_in[OPC_HI:OPC_LO]),
    .first_state (first_state),
    .legal       (legal)
  );

`ifdef SEQ_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  assign state       = st;
  assign instr_ready = (st == S_IDLE);
  assign accept      = instr_valid && instr_ready;
  // done marks the advancing cycle of a final state, so stepping cannot double-count
  assign done        = adv && ((st == S_LOAD) || (st == S_MOV) || (st == S_ARITH_WB));
  assign alu_sub     = (st == S_ARITH_G) && (instr[OPC_HI:OPC_LO] == OP_SUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      instr       <= '0;
      instr_count <= '0;
      illegal     <= 1'b0;
    end else begin
      illegal <= 1'b0;
      if (done) instr_count <= instr_count + 8'd1;
      case (st)
        S_IDLE: begin
          if (accept) begin
            instr   <= instr_in;
            st      <= first_state;
            illegal <= !legal;
          end
        end
        S_LOAD, S_MOV, S_ARITH_WB: if (adv) st <= S_IDLE;
        S_ARITH_A:                 if (adv) st <= S_ARITH_G;
        S_ARITH_G:                 if (adv) st <= S_ARITH_WB;
        default:                   st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes the expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_instr_sequencer;

  localparam logic [4:0] IDLE = 5'b00000;
  localparam logic [4:0] LD   = 5'b00001;
  localparam logic [4:0] MV   = 5'b00010;
  localparam logic [4:0] AA   = 5'b00011;
  localparam logic [4:0] AG   = 5'b00100;
  localparam logic [4:0] AW   = 5'b00101;

  localparam logic [22:0] I_MOV = 23'h150000;
  localparam logic [22:0] I_SUB = 23'h320000;
  localparam logic [22:0] I_ADD = 23'h243000;
  localparam logic [22:0] I_LD  = 23'h012000;
  localparam logic [22:0] I_ILL = 23'h7A5000;

  typedef struct packed {
    logic [4:0]  st;
    logic [22:0] ir;
    logic        rdy;
    logic        sub;
    logic        dn;
    logic        ill;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [22:0] instr_in = I_MOV;
  logic        instr_valid = 1'b1;
  logic        instr_ready;
  logic [22:0] instr;
  logic [4:0]  state;
  logic        alu_sub;
  logic        done;
  logic        illegal;
  logic [7:0]  instr_count;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step = 1'b1;
  logic        step_nxt = 1'b1;
`endif

  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  exp_t expq[$];

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .state       (state),
    .alu_sub     (alu_sub),
    .done        (done),
    .illegal     (illegal),
    .instr_count (instr_count)
`ifdef SEQ_SINGLE_STEP_EN
    ,
    .step        (step)
`endif
  );

  function automatic exp_t mk(input logic [4:0] st, input logic [22:0] ir, input logic sub,
                              input logic dn, input logic ill, input logic [7:0] cnt);
    exp_t e;
    e.st  = st;
    e.ir  = ir;
    e.rdy = (st == IDLE);
    e.sub = sub;
    e.dn  = dn;
    e.ill = ill;
    e.cnt = cnt;
    return e;
  endfunction

  // Inputs change just after the rising edge; e describes this cycle's outputs.
  task automatic cyc(input logic r, input logic v, input logic [22:0] i, input exp_t e);
    @(posedge clk);
    #1;
    rst_n       = r;
    instr_valid = v;
    instr_in    = i;
`ifdef SEQ_SINGLE_STEP_EN
    step        = step_nxt;
`endif
    expq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    exp_t g;
    forever begin
      @(negedge clk);
      ncyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        g = '{st: state, ir: instr, rdy: instr_ready, sub: alu_sub, dn: done, ill: illegal,
              cnt: instr_count};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL seq_chk cyc%0d got st=%b ir=%h rdy=%b sub=%b done=%b ill=%b cnt=%0d | exp st=%b ir=%h rdy=%b sub=%b done=%b ill=%b cnt=%0d",
                   ncyc, g.st, g.ir, g.rdy, g.sub, g.dn, g.ill, g.cnt,
                   e.st, e.ir, e.rdy, e.sub, e.dn, e.ill, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0]  cnt;
    logic [22:0] cur_ir;
    // reset held with a valid MOV present, then MOV accepted on the first edge after release
    cyc(1'b0, 1'b1, I_MOV, mk(IDLE, '0, 0, 0, 0, 8'd0));
    cyc(1'b1, 1'b1, I_MOV, mk(IDLE, '0, 0, 0, 0, 8'd0));
    cyc(1'b1, 1'b0, '0,    mk(MV, I_MOV, 0, 1, 0, 8'd0));
    // SUB: A, G with alu_sub, WB with done
    cyc(1'b1, 1'b1, I_SUB, mk(IDLE, I_MOV, 0, 0, 0, 8'd1));
    cyc(1'b1, 1'b0, '0,    mk(AA, I_SUB, 0, 0, 0, 8'd1));
    cyc(1'b1, 1'b0, '0,    mk(AG, I_SUB, 1, 0, 0, 8'd1));
    cyc(1'b1, 1'b0, '0,    mk(AW, I_SUB, 0, 1, 0, 8'd1));
    // illegal opcode: IR loads, stays IDLE, one illegal pulse, no count
    cyc(1'b1, 1'b1, I_ILL, mk(IDLE, I_SUB, 0, 0, 0, 8'd2));
    cyc(1'b1, 1'b0, '0,    mk(IDLE, I_ILL, 0, 0, 1, 8'd2));
    // ADD with valid held high (different word) through execution
    cyc(1'b1, 1'b1, I_ADD, mk(IDLE, I_ILL, 0, 0, 0, 8'd2));
    cyc(1'b1, 1'b1, I_LD,  mk(AA, I_ADD, 0, 0, 0, 8'd2));
    cyc(1'b1, 1'b1, I_LD,  mk(AG, I_ADD, 0, 0, 0, 8'd2));
    cyc(1'b1, 1'b1, I_LD,  mk(AW, I_ADD, 0, 1, 0, 8'd2));
    cyc(1'b1, 1'b1, I_LD,  mk(IDLE, I_ADD, 0, 0, 0, 8'd3));
    cyc(1'b1, 1'b1, I_ADD, mk(LD, I_LD, 0, 1, 0, 8'd3));
    cyc(1'b1, 1'b1, I_ADD, mk(IDLE, I_LD, 0, 0, 0, 8'd4));
    cyc(1'b1, 1'b0, '0,    mk(AA, I_ADD, 0, 0, 0, 8'd4));
    cyc(1'b1, 1'b0, '0,    mk(AG, I_ADD, 0, 0, 0, 8'd4));
    // short reset pulse in ARITH_G, released before the next rising edge
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cyc(1'b1, 1'b1, I_MOV, mk(IDLE, '0, 0, 0, 0, 8'd0));
    cyc(1'b1, 1'b0, '0,    mk(MV, I_MOV, 0, 1, 0, 8'd0));
    cnt    = 8'd1;
    cur_ir = I_MOV;
`ifdef SEQ_SINGLE_STEP_EN
    step_nxt = 1'b0;
    cyc(1'b1, 1'b1, I_ADD, mk(IDLE, I_MOV, 0, 0, 0, 8'd1));
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, '0, mk(AA, I_ADD, 0, 0, 0, 8'd1));
    step_nxt = 1'b1;
    cyc(1'b1, 1'b0, '0, mk(AA, I_ADD, 0, 0, 0, 8'd1));
    step_nxt = 1'b0;
    cyc(1'b1, 1'b0, '0, mk(AG, I_ADD, 0, 0, 0, 8'd1));
    step_nxt = 1'b1;
    cyc(1'b1, 1'b0, '0, mk(AG, I_ADD, 0, 0, 0, 8'd1));
    step_nxt = 1'b0;
    cyc(1'b1, 1'b0, '0, mk(AW, I_ADD, 0, 0, 0, 8'd1));
    step_nxt = 1'b1;
    cyc(1'b1, 1'b0, '0, mk(AW, I_ADD, 0, 1, 0, 8'd1));
    cnt    = 8'd2;
    cur_ir = I_ADD;
`endif
    // MOVs until the 256th completion since reset wraps the counter
    do begin
      cyc(1'b1, 1'b1, I_MOV, mk(IDLE, cur_ir, 0, 0, 0, cnt));
      cyc(1'b1, 1'b0, '0,    mk(MV, I_MOV, 0, 1, 0, cnt));
      cnt    = cnt + 8'd1;
      cur_ir = I_MOV;
    end while (cnt != 8'd0);
    cyc(1'b1, 1'b0, '0, mk(IDLE, I_MOV, 0, 0, 0, 8'd0));
    repeat (3) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
